// File: rtl/vjtag_cmd_proc_if.sv
// Command, bus and response signals of the VJtag system-side command processor.
// master is the processor's view; slave is the view of the CDC/bus environment around it.
interface vjtag_cmd_proc_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW+DW:0]    cmd_payload;
    logic              bus_req;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [DW-1:0]     bus_rdata;
    logic              rsp_req;
    logic [DW+1:0]     rsp_payload;

    modport master (
        input  cmd_valid, cmd_payload, bus_ready, bus_rvalid, bus_rdata,
        output cmd_ready, bus_req, bus_we, bus_addr, bus_wdata, rsp_req, rsp_payload
    );

    modport slave (
        output cmd_valid, cmd_payload, bus_ready, bus_rvalid, bus_rdata,
        input  cmd_ready, bus_req, bus_we, bus_addr, bus_wdata, rsp_req, rsp_payload
    );
endinterface

// File: rtl/vjtag_cmd_proc.sv
// Executes one VJtag host command at a time as a single bus read/write and returns
// a registered response pulse with a payload held until the next response.
module vjtag_cmd_proc #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    vjtag_cmd_proc_if.master io
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            cmd_ready_q, cmd_ready_nx;
    logic            bus_req_q, bus_req_nx;
    logic            bus_we_q, bus_we_nx;
    logic [AW-1:0]   bus_addr_q, bus_addr_nx;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_nx;
    logic            rsp_req_q, rsp_req_nx;
    logic [DW+1:0]   rsp_payload_q, rsp_payload_nx;
    logic            done;
    logic            timeout_hit;
    logic [DW-1:0]   rsp_data;

    assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        cmd_ready_nx   = cmd_ready_q;
        bus_req_nx     = bus_req_q;
        bus_we_nx      = bus_we_q;
        bus_addr_nx    = bus_addr_q;
        bus_wdata_nx   = bus_wdata_q;
        rsp_req_nx     = 1'b0;
        rsp_payload_nx = rsp_payload_q;
        done           = 1'b0;
        rsp_data       = '0;

        if (state != IDLE && TIMEOUT > 0) begin
            cnt_nx = cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (io.cmd_valid && cmd_ready_q) begin
                    bus_we_nx    = io.cmd_payload[AW+DW];
                    bus_addr_nx  = io.cmd_payload[AW+DW-1:DW];
                    bus_wdata_nx = io.cmd_payload[DW-1:0];
                    bus_req_nx   = 1'b1;
                    cmd_ready_nx = 1'b0;
                    cnt_nx       = '0;
                    state_nx     = REQ;
                end
            end
            REQ: begin
                if (io.bus_ready) begin
                    bus_req_nx = 1'b0;
                    if (bus_we_q) begin
                        done = 1'b1;
                    end else if (io.bus_rvalid) begin
                        done     = 1'b1;
                        rsp_data = io.bus_rdata;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (io.bus_rvalid) begin
                    done     = 1'b1;
                    rsp_data = io.bus_rdata;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A completion in the timeout cycle wins, so error is simply "not done".
        if (done || (state != IDLE && timeout_hit)) begin
            state_nx       = IDLE;
            bus_req_nx     = 1'b0;
            cmd_ready_nx   = 1'b1;
            rsp_req_nx     = 1'b1;
            rsp_payload_nx = {~done, bus_we_q, rsp_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_ready_q   <= 1'b1;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            rsp_req_q     <= 1'b0;
            rsp_payload_q <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            cmd_ready_q   <= cmd_ready_nx;
            bus_req_q     <= bus_req_nx;
            bus_we_q      <= bus_we_nx;
            bus_addr_q    <= bus_addr_nx;
            bus_wdata_q   <= bus_wdata_nx;
            rsp_req_q     <= rsp_req_nx;
            rsp_payload_q <= rsp_payload_nx;
        end
    end

    assign io.cmd_ready   = cmd_ready_q;
    assign io.bus_req     = bus_req_q;
    assign io.bus_we      = bus_we_q;
    assign io.bus_addr    = bus_addr_q;
    assign io.bus_wdata   = bus_wdata_q;
    assign io.rsp_req     = rsp_req_q;
    assign io.rsp_payload = rsp_payload_q;
endmodule

// File: tb/tb_vjtag_cmd_proc.sv
// Two processor instances (TIMEOUT 1024 and 8) driven by directed and random commands;
// expected responses are queued per instance and matched by a negedge monitor.
module tb_vjtag_cmd_proc;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int TO_A = 1024;
    localparam int TO_B = 8;

    typedef struct {
        int            cyc;
        logic [DW+1:0] pl;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic          cmd_valid   [2];
    logic [AW+DW:0] cmd_payload [2];
    logic          bus_ready   [2];
    logic          bus_rvalid  [2];
    logic [DW-1:0] bus_rdata   [2];
    logic          cmd_ready   [2];
    logic          bus_req     [2];
    logic          bus_we      [2];
    logic [AW-1:0] bus_addr    [2];
    logic [DW-1:0] bus_wdata   [2];
    logic          rsp_req     [2];
    logic [DW+1:0] rsp_payload [2];
    logic [DW+1:0] last_pl     [2];

    exp_t eq0[$];
    exp_t eq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vjtag_cmd_proc_if #(.AW(AW), .DW(DW)) bif ();

        assign bif.cmd_valid   = cmd_valid[g];
        assign bif.cmd_payload = cmd_payload[g];
        assign bif.bus_ready   = bus_ready[g];
        assign bif.bus_rvalid  = bus_rvalid[g];
        assign bif.bus_rdata   = bus_rdata[g];
        assign cmd_ready[g]    = bif.cmd_ready;
        assign bus_req[g]      = bif.bus_req;
        assign bus_we[g]       = bif.bus_we;
        assign bus_addr[g]     = bif.bus_addr;
        assign bus_wdata[g]    = bif.bus_wdata;
        assign rsp_req[g]      = bif.rsp_req;
        assign rsp_payload[g]  = bif.rsp_payload;

        vjtag_cmd_proc #(
            .AW     (AW),
            .DW     (DW),
            .TIMEOUT((g == 0) ? TO_A : TO_B)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .io   (bif.master)
        );
    end

    function automatic int to_of(input int k);
        return (k == 0) ? TO_A : TO_B;
    endfunction

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", k, name, act, exp, cyc);
    endtask

    task automatic chk_reset_vals(input int k);
        chk(k, "rst_cmd_ready",   64'(cmd_ready[k]),   64'(1));
        chk(k, "rst_bus_req",     64'(bus_req[k]),     64'(0));
        chk(k, "rst_bus_we",      64'(bus_we[k]),      64'(0));
        chk(k, "rst_bus_addr",    64'(bus_addr[k]),    64'(0));
        chk(k, "rst_bus_wdata",   64'(bus_wdata[k]),   64'(0));
        chk(k, "rst_rsp_req",     64'(rsp_req[k]),     64'(0));
        chk(k, "rst_rsp_payload", 64'(rsp_payload[k]), 64'(0));
    endtask

    // Monitor: every cycle, rsp_req must match the scoreboard; payload checked or held.
    initial begin : monitor
        exp_t e;
        bit   exp_now;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    last_pl[k] = '0;
                end else begin
                    exp_now = 1'b0;
                    if (k == 0) begin
                        while (eq0.size() > 0 && eq0[0].cyc < cyc) void'(eq0.pop_front());
                        if (eq0.size() > 0 && eq0[0].cyc == cyc) begin e = eq0.pop_front(); exp_now = 1'b1; end
                    end else begin
                        while (eq1.size() > 0 && eq1[0].cyc < cyc) void'(eq1.pop_front());
                        if (eq1.size() > 0 && eq1[0].cyc == cyc) begin e = eq1.pop_front(); exp_now = 1'b1; end
                    end
                    chk(k, "rsp_req", 64'(rsp_req[k]), 64'(exp_now));
                    if (exp_now) begin
                        chk(k, "rsp_payload", 64'(rsp_payload[k]), 64'(e.pl));
                        chk(k, "cmd_ready_at_rsp", 64'(cmd_ready[k]), 64'(1));
                        last_pl[k] = e.pl;
                    end else begin
                        chk(k, "rsp_payload_hold", 64'(rsp_payload[k]), 64'(last_pl[k]));
                    end
                end
            end
        end
    end

    // One command: rdy = cycles after bus_req first visible until bus_ready,
    // rv = further cycles until bus_rvalid (reads). noise 1 = random strays, 2 = held cmd_valid.
    task automatic do_txn(input int k, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int rdy, input int rv, input logic [DW-1:0] rd, input int noise);
        int   to, c, ce, reqlast, n;
        bit   tmo;
        exp_t e;
        to      = to_of(k);
        c       = we ? rdy : rdy + rv;
        tmo     = (to > 0) && (c > to - 1);
        ce      = tmo ? to - 1 : c;
        reqlast = (rdy < ce) ? rdy : ce;
        if (tmo)     e.pl = {1'b1, we, {DW{1'b0}}};
        else if (we) e.pl = {1'b0, 1'b1, {DW{1'b0}}};
        else         e.pl = {1'b0, 1'b0, rd};

        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(k, "accept_wait_bound", 64'(n < 64), 64'(1));
        if (n >= 64) return;

        cmd_valid[k]   = 1'b1;
        cmd_payload[k] = {we, addr, wd};
        e.cyc = cyc + 2 + ce;
        if (k == 0) eq0.push_back(e);
        else        eq1.push_back(e);

        for (int j = 0; j <= ce; j++) begin
            @(posedge clk);
            #1;
            if (noise == 2)      cmd_valid[k] = (j < 3);
            else if (noise == 1) cmd_valid[k] = ($urandom_range(0, 3) == 0);
            else                 cmd_valid[k] = 1'b0;
            cmd_payload[k] = {1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom)};
            bus_ready[k]   = (j == rdy);
            bus_rvalid[k]  = (!we && j == rdy + rv) ||
                             (noise == 1 && (we || j < rdy) && $urandom_range(0, 3) == 0);
            bus_rdata[k]   = (!we && j == rdy + rv) ? rd : DW'($urandom);
            chk(k, "bus_req", 64'(bus_req[k]), 64'(j <= reqlast));
            chk(k, "cmd_ready_busy", 64'(cmd_ready[k]), 64'(0));
            if (j == 0) begin
                chk(k, "bus_we",    64'(bus_we[k]),    64'(we));
                chk(k, "bus_addr",  64'(bus_addr[k]),  64'(addr));
                chk(k, "bus_wdata", 64'(bus_wdata[k]), 64'(wd));
            end
        end

        @(posedge clk);
        #1;
        cmd_valid[k]  = 1'b0;
        bus_ready[k]  = 1'b0;
        bus_rvalid[k] = 1'b0;
        chk(k, "bus_req_after", 64'(bus_req[k]), 64'(0));
    endtask

    task automatic idle_noise(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            bus_rvalid[k] = 1'($urandom_range(0, 1));
            bus_rdata[k]  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        bus_rvalid[k] = 1'b0;
    endtask

    // Read parked in WAIT, then asynchronous reset; its late rvalid must produce nothing.
    task automatic do_abort(input int k);
        cmd_valid[k]   = 1'b1;
        cmd_payload[k] = {1'b0, AW'(16'h0040), DW'(0)};
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
        bus_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        bus_ready[k] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(k);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bus_rvalid[k] = 1'b1;
        bus_rdata[k]  = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus_rvalid[k] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k]   = 1'b0;
            cmd_payload[k] = '0;
            bus_ready[k]   = 1'b0;
            bus_rvalid[k]  = 1'b0;
            bus_rdata[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk_reset_vals(k);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_txn(0, 1'b1, 16'h0010, 32'hCAFE_F00D, 0, 0, 32'h0, 0);
        do_txn(0, 1'b0, 16'h0020, 32'h0, 3, 5, 32'h1234_5678, 0);
        do_txn(0, 1'b0, 16'h0030, 32'h0, 2, 0, 32'hA5A5_A5A5, 0);
        do_txn(0, 1'b0, 16'h0050, 32'h0, 3, 2, 32'h5A5A_0F0F, 2);
        idle_noise(0, 4);
        do_abort(0);
        do_txn(0, 1'b1, 16'h0060, 32'h0102_0304, 1, 0, 32'h0, 0);
        do_txn(0, 1'b0, 16'h0070, 32'h0, 0, 0, 32'hFFFF_FFFF, 0);

        do_txn(1, 1'b1, 16'h0100, 32'h1111_2222, 20, 0, 32'h0, 0);
        do_txn(1, 1'b0, 16'h0104, 32'h0, 20, 0, 32'hDEAD_BEEF, 0);
        do_txn(1, 1'b1, 16'h0108, 32'h3333_4444, 7, 0, 32'h0, 0);
        do_txn(1, 1'b0, 16'h010C, 32'h0, 7, 0, 32'h7777_8888, 0);
        do_txn(1, 1'b0, 16'h0110, 32'h0, 3, 6, 32'h9999_AAAA, 0);
        do_txn(1, 1'b0, 16'h0114, 32'h0, 3, 4, 32'hBBBB_CCCC, 0);

        for (int i = 0; i < 160; i++) begin
            int k;
            bit we;
            int rdy;
            int rv;
            k   = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            rdy = int'($urandom_range(0, (k == 0) ? 12 : 10));
            rv  = int'($urandom_range(0, 6));
            do_txn(k, we, AW'($urandom), DW'($urandom), rdy, rv, DW'($urandom), 1);
            if ($urandom_range(0, 3) == 0) idle_noise(k, int'($urandom_range(1, 3)));
        end

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
